// File: rtl/sio_rx_fifo.sv
// 8N1 serial receiver with a byte FIFO behind a two-register I/O port.
// Register 0 reads/pops received data; register 1 reads status and accepts the error-reset/flush command.
module sio_rx_fifo #(
  parameter int unsigned BAUD_DIV        = 1302,
  parameter int unsigned FIFO_DEPTH_LOG2 = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce,
  input  logic       rx,
  input  logic       addr,
  input  logic       rd,
  input  logic       we,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       rx_ready
);

  localparam int unsigned TW    = $clog2(BAUD_DIV);
  localparam int unsigned AW    = FIFO_DEPTH_LOG2;
  localparam int unsigned CW    = FIFO_DEPTH_LOG2 + 1;
  localparam int unsigned DEPTH = 1 << FIFO_DEPTH_LOG2;

  localparam logic [TW-1:0] HALF_M1 = TW'(BAUD_DIV / 2 - 1);
  localparam logic [TW-1:0] FULL_M1 = TW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  logic          rx_meta_q, rx_sync_q;
  state_t        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          push_req;
  logic          frame_set;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overrun_q, overrun_d;
  logic          framing_q, framing_d;
  logic          rx_ready_q;
  logic          rd_q;
  logic [7:0]    data_out_q, data_out_d;

  logic          rd_rise, pop, push_ok, overrun_set;
  logic          clr_err, flush, full;
  logic [7:0]    status;
  logic          unused_data_bits;

  assign unused_data_bits = ^{data_in[7], data_in[5], data_in[3:0]};

  // ---------------------------------------------------------------- sync
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // ---------------------------------------------------------------- receiver FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    push_req  = 1'b0;
    frame_set = 1'b0;
    if (ce) begin
      unique case (state_q)
        S_IDLE: begin
          if (!rx_sync_q) begin
            state_d = S_START;
            tick_d  = '0;
          end
        end
        S_START: begin
          if (tick_q == HALF_M1) begin
            tick_d = '0;
            bit_d  = '0;
            state_d = rx_sync_q ? S_IDLE : S_DATA;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
        S_DATA: begin
          if (tick_q == FULL_M1) begin
            shift_d = {rx_sync_q, shift_q[7:1]};
            tick_d  = '0;
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = S_STOP;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
        S_STOP: begin
          if (tick_q == FULL_M1) begin
            tick_d = '0;
            if (rx_sync_q) begin
              push_req = 1'b1;
              state_d  = S_IDLE;
            end else begin
              frame_set = 1'b1;
              state_d   = S_BREAK;
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
        // Line held low past the stop bit: wait for it to return high.
        S_BREAK: begin
          if (rx_sync_q) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- FIFO and bus
  assign rd_rise     = rd & ~rd_q;
  assign pop         = rd_rise & ~addr & (count_q != '0);
  assign full        = (count_q == DEPTH_C);
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign push_ok     = push_req & (~full | pop);
  assign overrun_set = push_req & ~push_ok;
  assign clr_err     = we & addr & data_in[4];
  assign flush       = we & addr & data_in[6];
  assign status      = {4'b0000, framing_q, overrun_q, full, rx_ready_q};

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      unique case ({push_ok, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    overrun_d = clr_err ? 1'b0 : overrun_q;
    framing_d = clr_err ? 1'b0 : framing_q;
    if (overrun_set) overrun_d = 1'b1;
    if (frame_set)   framing_d = 1'b1;
  end

  // Data reads latch only on the rd edge so a held strobe keeps showing the popped byte.
  always_comb begin
    data_out_d = data_out_q;
    if (rd) begin
      if (addr)         data_out_d = status;
      else if (rd_rise) data_out_d = (count_q != '0) ? mem[rd_ptr_q] : 8'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr_q] <= shift_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overrun_q  <= 1'b0;
      framing_q  <= 1'b0;
      rx_ready_q <= 1'b0;
      rd_q       <= 1'b0;
      data_out_q <= 8'h00;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overrun_q  <= overrun_d;
      framing_q  <= framing_d;
      rx_ready_q <= (count_d != '0);
      rd_q       <= rd;
      data_out_q <= data_out_d;
    end
  end

  assign data_out = data_out_q;
  assign rx_ready = rx_ready_q;

endmodule

// File: doc/sio_rx_fifo.md
Name: sio_rx_fifo

Overview:
Serial receive front-end that sits between the board rx pin and the CPU I/O bus, alongside the existing USART. It deserializes 8N1 async frames from rx and buffers the bytes in a FIFO. The CPU reads data and status through a two-register, USART-style I/O port, so short bursts survive slow monitor polling.

Parameters:
BAUD_DIV, 1302, ce ticks per bit period (25 MHz clk, ce = clk/2, 9600 baud); must be >= 4
FIFO_DEPTH_LOG2, 4, log2 of FIFO depth (default 16 entries)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
ce  input  1  clock enable (clk/2 strobe); all bit timing advances only when ce=1
rx  input  1  async serial input, idle high
addr  input  1  register select: 0 = data, 1 = status/command
rd  input  1  read strobe, may stay high for several clk cycles
we  input  1  write strobe
data_in  input  8  write data
data_out  output  8  registered read data
rx_ready  output  1  FIFO non-empty (usable as interrupt request)

Behaviour:
- Reset (synchronous, on clk when reset=1): FSM to IDLE; FIFO empty (rd_ptr = wr_ptr = 0, count = 0); overrun, framing and rx_ready = 0; data_out = 8'h00; synchronizer flops = 1.
- rx passes through a 2-flop synchronizer clocked every clk; the FSM uses only the synchronized value.
- Bit counter counts ce ticks; no state changes when ce=0.
- FSM:
  - IDLE: on synchronized rx=0, go to START and clear the tick counter.
  - START: after BAUD_DIV/2 ticks (integer divide), resample. If rx=1 (glitch), return to IDLE with no flag. If rx=0, go to DATA with bit index 0 and the tick counter cleared.
  - DATA: every BAUD_DIV ticks, sample rx into the shift register LSB-first. After bit 7 is sampled, go to STOP.
  - STOP: after BAUD_DIV ticks, sample rx.
    - rx=1: push the byte.
    - rx=0: set framing, discard the byte, and stay in STOP until rx=1, then go to IDLE (break handling).
    - In both cases, IDLE is the next state once rx=1.
- FIFO push:
  - If count < depth, write at wr_ptr, wr_ptr+1 (wraps modulo depth), count+1.
  - If full, the byte is dropped and overrun is set. FIFO contents are unchanged.
- Bus read (registered; data_out is valid on the clk after rd rises; one-cycle latency matching the synchronous memories):
  - addr=0: data_out = FIFO[rd_ptr] (8'h00 if empty).
  - addr=0 pops only on the rising edge of rd (rd & ~rd_q). A held rd pops exactly once. A pop while empty has no effect.
  - addr=1: data_out = {4'b0, framing, overrun, full, rx_ready}. A status read never pops.
  - data_out holds its value while rd=0.
- Bus write:
  - we with addr=1 and data_in[4]=1 clears overrun and framing (error-reset bit, as in the USART command word).
  - data_in[6]=1 additionally flushes the FIFO (pointers and count to 0).
  - Writes with addr=0 are ignored.
- Simultaneous push and pop in one clk:
  - Both are performed and count is unchanged.
  - When full, a simultaneous pop frees the slot first, so the push succeeds and no overrun is set.
- Flag priority: a flag-set event in the same clk as an error-reset write leaves the flag set (set wins).
- rx_ready = (count != 0), registered alongside count.
- Reset mid-frame: a partial byte is discarded, and reception resumes at the next falling edge after reset releases.

Test Plan:
1. Send 8'hA5 at BAUD_DIV=8 -> status reads 8'h01; data read returns 8'hA5; next status reads 8'h00.
2. Send 16 bytes 8'h00..8'h0F without reading -> status = 8'h03 (ready+full). A 17th byte 8'hFF -> status 8'h07. Reads return 8'h00..8'h0F in order and 8'hFF is never returned.
3. Send a frame with stop bit = 0, data 8'h3C -> FIFO stays empty and status = 8'h08. Write addr1 data 8'h10 -> status 8'h00.
4. Hold rd=1, addr=0 for 5 clk with 2 bytes queued -> exactly one pop; count goes 2->1.
5. rx low pulse of BAUD_DIV/4 ticks -> no byte and no flag; FSM is back in IDLE.
6. Assert reset in the middle of bit 4 of a frame, then send 8'h5A -> only 8'h5A is received. Separately, push and pop in the same clk with the FIFO full -> count stays 16 and overrun stays 0.
